// File: rtl/cache_pkg.sv
// Shared types and address helpers for the N-way set-associative cache controller.
package cache_pkg;

    localparam int unsigned DEF_ADDR_W      = 16;
    localparam int unsigned DEF_DATA_W      = 8;
    localparam int unsigned DEF_WAYS        = 4;
    localparam int unsigned DEF_SETS        = 16;
    localparam int unsigned DEF_BLOCK_WORDS = 4;

    localparam int unsigned DEF_OFF_W = $clog2(DEF_BLOCK_WORDS);
    localparam int unsigned DEF_IDX_W = $clog2(DEF_SETS);
    localparam int unsigned DEF_TAG_W = DEF_ADDR_W - DEF_IDX_W - DEF_OFF_W;

    typedef enum logic [2:0] {
        IDLE,
        LOOKUP,
        WB,
        REFILL,
        RESP
    } cache_state_t;

    typedef struct packed {
        logic [31:0] tag;
        logic [31:0] index;
        logic [31:0] offset;
    } addr_fields_t;

    // Right-justified {tag, index, offset} split for any geometry up to 32 address bits.
    function automatic addr_fields_t split_addr(input logic [31:0] addr,
                                                input int unsigned idx_w,
                                                input int unsigned off_w);
        addr_fields_t f;
        f.offset = addr & ((32'd1 << off_w) - 32'd1);
        f.index  = (addr >> off_w) & ((32'd1 << idx_w) - 32'd1);
        f.tag    = addr >> (off_w + idx_w);
        return f;
    endfunction

endpackage

// File: rtl/cache_lru_ages.sv
// Per-set age-based LRU tracking; age WAYS-1 marks the least recently used way.
module cache_lru_ages #(
    parameter int unsigned WAYS = 4,
    parameter int unsigned SETS = 16
) (
    input  logic                    clk,
    input  logic                    rst_b,
    input  logic                    upd_en,
    input  logic [$clog2(SETS)-1:0] upd_set,
    input  logic [$clog2(WAYS)-1:0] upd_way,
    input  logic [$clog2(SETS)-1:0] victim_set,
    output logic [$clog2(WAYS)-1:0] victim_way
);
    localparam int unsigned AGE_W = $clog2(WAYS);

    logic [AGE_W-1:0] age [SETS][WAYS];
    logic [AGE_W-1:0] upd_age;

    assign upd_age = age[upd_set][upd_way];

    // Accessed way becomes youngest; only younger ways age, so ages stay a permutation.
    always_ff @(posedge clk) begin
        if (!rst_b) begin
            for (int s = 0; s < int'(SETS); s++) begin
                for (int w = 0; w < int'(WAYS); w++) begin
                    age[s][w] <= AGE_W'(w);
                end
            end
        end else if (upd_en) begin
            for (int w = 0; w < int'(WAYS); w++) begin
                if (AGE_W'(w) == upd_way) begin
                    age[upd_set][w] <= '0;
                end else if (age[upd_set][w] < upd_age) begin
                    age[upd_set][w] <= age[upd_set][w] + AGE_W'(1);
                end
            end
        end
    end

    always_comb begin
        victim_way = '0;
        for (int w = 0; w < int'(WAYS); w++) begin
            if (age[victim_set][w] == AGE_W'(WAYS - 1)) begin
                victim_way = AGE_W'(w);
            end
        end
    end

endmodule

// File: rtl/cache_controller_nway.sv
// N-way set-associative write-back, write-allocate cache controller with
// valid/ready handshakes toward the CPU and the backing memory.
module cache_controller_nway
    import cache_pkg::*;
#(
    parameter int unsigned ADDR_W      = DEF_ADDR_W,
    parameter int unsigned DATA_W      = DEF_DATA_W,
    parameter int unsigned WAYS        = DEF_WAYS,
    parameter int unsigned SETS        = DEF_SETS,
    parameter int unsigned BLOCK_WORDS = DEF_BLOCK_WORDS
) (
    input  logic              clk,
    input  logic              rst_b,
    input  logic              cpu_req_valid,
    output logic              cpu_req_ready,
    input  logic              cpu_req_we,
    input  logic [ADDR_W-1:0] cpu_req_addr,
    input  logic [DATA_W-1:0] cpu_req_wdata,
    output logic              cpu_resp_valid,
    output logic [DATA_W-1:0] cpu_resp_rdata,
    output logic              cpu_resp_hit,
    output logic              mem_req_valid,
    input  logic              mem_req_ready,
    output logic              mem_req_we,
    output logic [ADDR_W-1:0] mem_req_addr,
    output logic [DATA_W-1:0] mem_req_wdata,
    input  logic              mem_resp_valid,
    input  logic [DATA_W-1:0] mem_resp_rdata
);
    localparam int unsigned OFF_W = $clog2(BLOCK_WORDS);
    localparam int unsigned IDX_W = $clog2(SETS);
    localparam int unsigned TAG_W = ADDR_W - IDX_W - OFF_W;
    localparam int unsigned WAY_W = $clog2(WAYS);
    localparam logic [OFF_W-1:0] LAST_BEAT = OFF_W'(BLOCK_WORDS - 1);

    cache_state_t      state;
    logic              req_we;
    logic [TAG_W-1:0]  req_tag;
    logic [IDX_W-1:0]  req_idx;
    logic [OFF_W-1:0]  req_off;
    logic [DATA_W-1:0] req_wdata;
    logic [WAY_W-1:0]  way_r;
    logic [OFF_W-1:0]  beat;
    logic [OFF_W-1:0]  beat_nxt;
    logic              refill_wait;

    logic [TAG_W-1:0]  tag_mem   [SETS][WAYS];
    logic              valid_mem [SETS][WAYS];
    logic              dirty_mem [SETS][WAYS];
    logic [DATA_W-1:0] data_mem  [SETS][WAYS][BLOCK_WORDS];

    addr_fields_t     acc_f;
    logic             unused_fields;
    logic             hit_any;
    logic             inv_any;
    logic [WAY_W-1:0] hit_way;
    logic [WAY_W-1:0] inv_way;
    logic [WAY_W-1:0] lru_victim;
    logic [WAY_W-1:0] vict_way;

    assign acc_f         = split_addr(32'(cpu_req_addr), IDX_W, OFF_W);
    assign unused_fields = &{1'b0, acc_f};
    assign beat_nxt      = beat + OFF_W'(1);

    cache_lru_ages #(.WAYS(WAYS), .SETS(SETS)) u_lru (
        .clk        (clk),
        .rst_b      (rst_b),
        .upd_en     (state == RESP),
        .upd_set    (req_idx),
        .upd_way    (way_r),
        .victim_set (req_idx),
        .victim_way (lru_victim)
    );

    // Parallel tag compare; descending scan leaves the lowest-index match/invalid way.
    always_comb begin
        hit_any = 1'b0;
        hit_way = '0;
        inv_any = 1'b0;
        inv_way = '0;
        for (int w = int'(WAYS) - 1; w >= 0; w--) begin
            if (valid_mem[req_idx][w] && (tag_mem[req_idx][w] == req_tag)) begin
                hit_any = 1'b1;
                hit_way = WAY_W'(w);
            end
            if (!valid_mem[req_idx][w]) begin
                inv_any = 1'b1;
                inv_way = WAY_W'(w);
            end
        end
        vict_way = inv_any ? inv_way : lru_victim;
    end

    always_ff @(posedge clk) begin
        if (!rst_b) begin
            state          <= IDLE;
            cpu_req_ready  <= 1'b0;
            cpu_resp_valid <= 1'b0;
            cpu_resp_hit   <= 1'b0;
            cpu_resp_rdata <= '0;
            mem_req_valid  <= 1'b0;
            mem_req_we     <= 1'b0;
            mem_req_addr   <= '0;
            mem_req_wdata  <= '0;
            refill_wait    <= 1'b0;
            beat           <= '0;
            for (int s = 0; s < int'(SETS); s++) begin
                for (int w = 0; w < int'(WAYS); w++) begin
                    valid_mem[s][w] <= 1'b0;
                    dirty_mem[s][w] <= 1'b0;
                end
            end
        end else begin
            cpu_resp_valid <= 1'b0;
            case (state)
                IDLE: begin
                    cpu_req_ready <= 1'b1;
                    if (cpu_req_valid && cpu_req_ready) begin
                        cpu_req_ready <= 1'b0;
                        req_we        <= cpu_req_we;
                        req_wdata     <= cpu_req_wdata;
                        req_tag       <= acc_f.tag[TAG_W-1:0];
                        req_idx       <= acc_f.index[IDX_W-1:0];
                        req_off       <= acc_f.offset[OFF_W-1:0];
                        state         <= LOOKUP;
                    end
                end
                LOOKUP: begin
                    beat <= '0;
                    if (hit_any) begin
                        way_r          <= hit_way;
                        cpu_resp_valid <= 1'b1;
                        cpu_resp_hit   <= 1'b1;
                        cpu_resp_rdata <= req_we ? req_wdata : data_mem[req_idx][hit_way][req_off];
                        state          <= RESP;
                    end else begin
                        way_r         <= vict_way;
                        mem_req_valid <= 1'b1;
                        if (valid_mem[req_idx][vict_way] && dirty_mem[req_idx][vict_way]) begin
                            mem_req_we    <= 1'b1;
                            mem_req_addr  <= {tag_mem[req_idx][vict_way], req_idx, {OFF_W{1'b0}}};
                            mem_req_wdata <= data_mem[req_idx][vict_way][0];
                            state         <= WB;
                        end else begin
                            mem_req_we   <= 1'b0;
                            mem_req_addr <= {req_tag, req_idx, {OFF_W{1'b0}}};
                            state        <= REFILL;
                        end
                    end
                end
                WB: begin
                    if (mem_req_ready) begin
                        if (beat == LAST_BEAT) begin
                            beat          <= '0;
                            mem_req_we    <= 1'b0;
                            mem_req_addr  <= {req_tag, req_idx, {OFF_W{1'b0}}};
                            mem_req_wdata <= '0;
                            state         <= REFILL;
                        end else begin
                            beat          <= beat_nxt;
                            mem_req_addr  <= {tag_mem[req_idx][way_r], req_idx, beat_nxt};
                            mem_req_wdata <= data_mem[req_idx][way_r][beat_nxt];
                        end
                    end
                end
                REFILL: begin
                    // One beat outstanding: request, then wait for its data.
                    if (!refill_wait) begin
                        if (mem_req_ready) begin
                            mem_req_valid <= 1'b0;
                            refill_wait   <= 1'b1;
                        end
                    end else if (mem_resp_valid) begin
                        data_mem[req_idx][way_r][beat] <= mem_resp_rdata;
                        refill_wait <= 1'b0;
                        if (beat == LAST_BEAT) begin
                            beat                    <= '0;
                            valid_mem[req_idx][way_r] <= 1'b1;
                            dirty_mem[req_idx][way_r] <= 1'b0;
                            tag_mem[req_idx][way_r]   <= req_tag;
                            cpu_resp_valid          <= 1'b1;
                            cpu_resp_hit            <= 1'b0;
                            if (req_we) begin
                                cpu_resp_rdata <= req_wdata;
                            end else if (req_off == beat) begin
                                cpu_resp_rdata <= mem_resp_rdata;
                            end else begin
                                cpu_resp_rdata <= data_mem[req_idx][way_r][req_off];
                            end
                            state <= RESP;
                        end else begin
                            beat          <= beat_nxt;
                            mem_req_valid <= 1'b1;
                            mem_req_addr  <= {req_tag, req_idx, beat_nxt};
                        end
                    end
                end
                RESP: begin
                    if (req_we) begin
                        data_mem[req_idx][way_r][req_off] <= req_wdata;
                        dirty_mem[req_idx][way_r]         <= 1'b1;
                    end
                    cpu_req_ready <= 1'b1;
                    state         <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_cache_controller_nway.sv
// Directed self-checking bench for cache_controller_nway with a one-beat-latency memory model.
module tb_cache_controller_nway;

    typedef struct {
        logic        we;
        logic [15:0] addr;
        logic [7:0]  wdata;
    } beat_t;

    logic        clk = 1'b0;
    logic        rst_b;
    logic        cpu_req_valid;
    logic        cpu_req_ready;
    logic        cpu_req_we;
    logic [15:0] cpu_req_addr;
    logic [7:0]  cpu_req_wdata;
    logic        cpu_resp_valid;
    logic [7:0]  cpu_resp_rdata;
    logic        cpu_resp_hit;
    logic        mem_req_valid;
    logic        mem_req_ready;
    logic        mem_req_we;
    logic [15:0] mem_req_addr;
    logic [7:0]  mem_req_wdata;
    logic        mem_resp_valid = 1'b0;
    logic [7:0]  mem_resp_rdata = 8'h00;

    int n_asrt = 0;
    int n_fail = 0;

    beat_t      log_q[$];
    logic [7:0] wmem [logic [15:0]];

    cache_controller_nway dut (
        .clk            (clk),
        .rst_b          (rst_b),
        .cpu_req_valid  (cpu_req_valid),
        .cpu_req_ready  (cpu_req_ready),
        .cpu_req_we     (cpu_req_we),
        .cpu_req_addr   (cpu_req_addr),
        .cpu_req_wdata  (cpu_req_wdata),
        .cpu_resp_valid (cpu_resp_valid),
        .cpu_resp_rdata (cpu_resp_rdata),
        .cpu_resp_hit   (cpu_resp_hit),
        .mem_req_valid  (mem_req_valid),
        .mem_req_ready  (mem_req_ready),
        .mem_req_we     (mem_req_we),
        .mem_req_addr   (mem_req_addr),
        .mem_req_wdata  (mem_req_wdata),
        .mem_resp_valid (mem_resp_valid),
        .mem_resp_rdata (mem_resp_rdata)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] mem_val(input logic [15:0] a);
        logic [7:0] lo;
        lo = a[7:0];
        if (wmem.exists(a)) return wmem[a];
        return lo ^ 8'h5A;
    endfunction

    // Memory model: logs every handshaked beat, answers reads one cycle later.
    always @(posedge clk) begin
        mem_resp_valid <= 1'b0;
        if (mem_req_valid && mem_req_ready) begin
            log_q.push_back('{mem_req_we, mem_req_addr, mem_req_wdata});
            if (mem_req_we) begin
                wmem[mem_req_addr] = mem_req_wdata;
            end else begin
                mem_resp_valid <= 1'b1;
                mem_resp_rdata <= mem_val(mem_req_addr);
            end
        end
    end

    task automatic issue(input logic we, input logic [15:0] a, input logic [7:0] d);
        int n;
        n = 0;
        @(negedge clk);
        while (cpu_req_ready !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        n_asrt++;
        if (cpu_req_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL accept_timeout addr=%h: ready=%b, required 1", a, cpu_req_ready);
        end
        cpu_req_valid = 1'b1;
        cpu_req_we    = we;
        cpu_req_addr  = a;
        cpu_req_wdata = d;
        @(posedge clk);
        @(negedge clk);
        cpu_req_valid = 1'b0;
    endtask

    task automatic access(input logic we, input logic [15:0] a, input logic [7:0] d,
                          output logic [7:0] rd, output logic hit,
                          output int lat, output int nbeats);
        int base;
        base = log_q.size();
        issue(we, a, d);
        lat = 1;
        while (cpu_resp_valid !== 1'b1 && lat < 500) begin
            @(negedge clk);
            lat++;
        end
        n_asrt++;
        if (cpu_resp_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL resp_timeout addr=%h: resp_valid=%b, required 1", a, cpu_resp_valid);
        end
        rd     = cpu_resp_rdata;
        hit    = cpu_resp_hit;
        nbeats = log_q.size() - base;
    endtask

    task automatic test_reset();
        rst_b = 1'b0;
        repeat (3) @(negedge clk);
        n_asrt++; if (cpu_req_ready !== 1'b0) begin n_fail++; $display("FAIL rst_ready: got %b, expected 0", cpu_req_ready); end
        n_asrt++; if (cpu_resp_valid !== 1'b0) begin n_fail++; $display("FAIL rst_resp_valid: got %b, expected 0", cpu_resp_valid); end
        n_asrt++; if (cpu_resp_hit !== 1'b0) begin n_fail++; $display("FAIL rst_resp_hit: got %b, expected 0", cpu_resp_hit); end
        n_asrt++; if (cpu_resp_rdata !== 8'h00) begin n_fail++; $display("FAIL rst_resp_rdata: got %h, expected 00", cpu_resp_rdata); end
        n_asrt++; if (mem_req_valid !== 1'b0) begin n_fail++; $display("FAIL rst_mem_valid: got %b, expected 0", mem_req_valid); end
        n_asrt++; if (mem_req_we !== 1'b0) begin n_fail++; $display("FAIL rst_mem_we: got %b, expected 0", mem_req_we); end
        n_asrt++; if (mem_req_addr !== 16'h0000) begin n_fail++; $display("FAIL rst_mem_addr: got %h, expected 0000", mem_req_addr); end
        n_asrt++; if (mem_req_wdata !== 8'h00) begin n_fail++; $display("FAIL rst_mem_wdata: got %h, expected 00", mem_req_wdata); end
        rst_b = 1'b1;
        @(negedge clk);
        n_asrt++; if (cpu_req_ready !== 1'b1) begin n_fail++; $display("FAIL rst_release_ready: got %b, expected 1", cpu_req_ready); end
    endtask

    task automatic test_read_miss_hit();
        logic [7:0] rd;
        logic       h;
        int         lat, nb, base;
        base = log_q.size();
        access(1'b0, 16'h0040, 8'h00, rd, h, lat, nb);
        n_asrt++; if (rd !== 8'h1A) begin n_fail++; $display("FAIL miss_rdata: got %h, expected 1a", rd); end
        n_asrt++; if (h !== 1'b0) begin n_fail++; $display("FAIL miss_hit: got %b, expected 0", h); end
        n_asrt++; if (nb !== 4) begin n_fail++; $display("FAIL miss_beats: got %0d, expected 4", nb); end
        for (int i = 0; i < nb && i < 4; i++) begin
            n_asrt++;
            if (log_q[base+i].we !== 1'b0 || log_q[base+i].addr !== 16'h0040 + 16'(i)) begin
                n_fail++;
                $display("FAIL miss_beat%0d: got we=%b addr=%h, expected we=0 addr=%h",
                         i, log_q[base+i].we, log_q[base+i].addr, 16'h0040 + 16'(i));
            end
        end
        access(1'b0, 16'h0042, 8'h00, rd, h, lat, nb);
        n_asrt++; if (rd !== 8'h18) begin n_fail++; $display("FAIL hit_rdata: got %h, expected 18", rd); end
        n_asrt++; if (h !== 1'b1) begin n_fail++; $display("FAIL hit_flag: got %b, expected 1", h); end
        n_asrt++; if (lat !== 2) begin n_fail++; $display("FAIL hit_latency: got %0d, expected 2", lat); end
        n_asrt++; if (nb !== 0) begin n_fail++; $display("FAIL hit_no_mem: got %0d beats, expected 0", nb); end
    endtask

    task automatic test_write_hit();
        logic [7:0] rd;
        logic       h;
        int         lat, nb;
        access(1'b1, 16'h0041, 8'hA5, rd, h, lat, nb);
        n_asrt++; if (h !== 1'b1) begin n_fail++; $display("FAIL whit_flag: got %b, expected 1", h); end
        n_asrt++; if (rd !== 8'hA5) begin n_fail++; $display("FAIL whit_rdata: got %h, expected a5", rd); end
        n_asrt++; if (nb !== 0) begin n_fail++; $display("FAIL whit_no_mem: got %0d beats, expected 0", nb); end
        access(1'b0, 16'h0041, 8'h00, rd, h, lat, nb);
        n_asrt++; if (rd !== 8'hA5 || h !== 1'b1) begin n_fail++; $display("FAIL whit_readback: got %h/%b, expected a5/1", rd, h); end
    endtask

    task automatic test_fill_evict();
        logic [7:0]  rd;
        logic        h;
        int          lat, nb, base;
        logic [15:0] fill_a [7];
        logic [7:0]  fill_d [7];
        logic        fill_h [7];
        logic [7:0]  exp_wb [4];
        fill_a = '{16'h0000, 16'h0040, 16'h0080, 16'h00C0, 16'h0000, 16'h0080, 16'h00C0};
        fill_d = '{8'h5A, 8'h1A, 8'hDA, 8'h9A, 8'h5A, 8'hDA, 8'h9A};
        fill_h = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
        exp_wb = '{8'h1A, 8'hA5, 8'h18, 8'h19};
        for (int i = 0; i < 7; i++) begin
            access(1'b0, fill_a[i], 8'h00, rd, h, lat, nb);
            n_asrt++;
            if (rd !== fill_d[i] || h !== fill_h[i]) begin
                n_fail++;
                $display("FAIL fill_%0d addr=%h: got %h/%b, expected %h/%b", i, fill_a[i], rd, h, fill_d[i], fill_h[i]);
            end
        end
        base = log_q.size();
        access(1'b0, 16'h0100, 8'h00, rd, h, lat, nb);
        n_asrt++; if (rd !== 8'h5A || h !== 1'b0) begin n_fail++; $display("FAIL evict_resp: got %h/%b, expected 5a/0", rd, h); end
        n_asrt++; if (nb !== 8) begin n_fail++; $display("FAIL evict_beats: got %0d, expected 8", nb); end
        for (int i = 0; i < nb && i < 8; i++) begin
            logic        ew;
            logic [15:0] ea;
            logic [7:0]  ed;
            ew = (i < 4);
            ea = ew ? 16'h0040 + 16'(i) : 16'h0100 + 16'(i - 4);
            ed = ew ? exp_wb[i] : log_q[base+i].wdata;
            n_asrt++;
            if (log_q[base+i].we !== ew || log_q[base+i].addr !== ea || log_q[base+i].wdata !== ed) begin
                n_fail++;
                $display("FAIL evict_beat%0d: got we=%b addr=%h data=%h, expected we=%b addr=%h data=%h",
                         i, log_q[base+i].we, log_q[base+i].addr, log_q[base+i].wdata, ew, ea, ed);
            end
        end
        access(1'b0, 16'h0000, 8'h00, rd, h, lat, nb);
        n_asrt++; if (rd !== 8'h5A || h !== 1'b1) begin n_fail++; $display("FAIL evict_survivor: got %h/%b, expected 5a/1", rd, h); end
    endtask

    task automatic test_mem_stall();
        int base, n, bad, lat;
        base = log_q.size();
        mem_req_ready = 1'b0;
        issue(1'b0, 16'h0300, 8'h00);
        n = 0;
        while (mem_req_valid !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        n_asrt++;
        if (mem_req_valid !== 1'b1 || mem_req_addr !== 16'h0300 || mem_req_we !== 1'b0) begin
            n_fail++;
            $display("FAIL stall_first_beat: got v=%b addr=%h we=%b, expected 1/0300/0", mem_req_valid, mem_req_addr, mem_req_we);
        end
        bad = 0;
        repeat (5) begin
            @(negedge clk);
            if (mem_req_valid !== 1'b1 || mem_req_addr !== 16'h0300 || mem_req_we !== 1'b0) bad++;
        end
        n_asrt++; if (bad !== 0) begin n_fail++; $display("FAIL stall_stable: got %0d unstable cycles, expected 0", bad); end
        n_asrt++; if (log_q.size() !== base) begin n_fail++; $display("FAIL stall_no_beat: got %0d beats, expected 0", log_q.size() - base); end
        mem_req_ready = 1'b1;
        lat = 0;
        while (cpu_resp_valid !== 1'b1 && lat < 500) begin
            @(negedge clk);
            lat++;
        end
        n_asrt++;
        if (cpu_resp_valid !== 1'b1 || cpu_resp_rdata !== 8'h5A || cpu_resp_hit !== 1'b0) begin
            n_fail++;
            $display("FAIL stall_resp: got v=%b %h/%b, expected 1 5a/0", cpu_resp_valid, cpu_resp_rdata, cpu_resp_hit);
        end
        n_asrt++; if (log_q.size() - base !== 4) begin n_fail++; $display("FAIL stall_beats: got %0d, expected 4", log_q.size() - base); end
        for (int i = 0; i < log_q.size() - base && i < 4; i++) begin
            n_asrt++;
            if (log_q[base+i].addr !== 16'h0300 + 16'(i)) begin
                n_fail++;
                $display("FAIL stall_beat%0d: got %h, expected %h", i, log_q[base+i].addr, 16'h0300 + 16'(i));
            end
        end
    endtask

    task automatic test_reset_midop();
        logic [7:0] rd;
        logic       h;
        int         n, lat, nb;
        issue(1'b0, 16'h0400, 8'h00);
        n = 0;
        while (!(mem_req_valid === 1'b1 && mem_req_addr === 16'h0401) && n < 100) begin
            @(negedge clk);
            n++;
        end
        n_asrt++; if (mem_req_addr !== 16'h0401) begin n_fail++; $display("FAIL midrst_second_beat: got %h, expected 0401", mem_req_addr); end
        rst_b = 1'b0;
        @(negedge clk);
        n_asrt++; if (mem_req_valid !== 1'b0) begin n_fail++; $display("FAIL midrst_mem_valid: got %b, expected 0", mem_req_valid); end
        n_asrt++; if (cpu_req_ready !== 1'b0) begin n_fail++; $display("FAIL midrst_ready: got %b, expected 0", cpu_req_ready); end
        n_asrt++; if (mem_req_addr !== 16'h0000) begin n_fail++; $display("FAIL midrst_mem_addr: got %h, expected 0000", mem_req_addr); end
        rst_b = 1'b1;
        @(negedge clk);
        n_asrt++; if (cpu_req_ready !== 1'b1) begin n_fail++; $display("FAIL midrst_idle_ready: got %b, expected 1", cpu_req_ready); end
        n_asrt++; if (cpu_resp_valid !== 1'b0 || mem_req_valid !== 1'b0) begin n_fail++; $display("FAIL midrst_quiet: got resp=%b mem=%b, expected 0/0", cpu_resp_valid, mem_req_valid); end
        access(1'b0, 16'h0040, 8'h00, rd, h, lat, nb);
        n_asrt++; if (rd !== 8'h1A || h !== 1'b0 || nb !== 4) begin n_fail++; $display("FAIL midrst_reread: got %h/%b/%0d, expected 1a/0/4", rd, h, nb); end
        access(1'b0, 16'h0041, 8'h00, rd, h, lat, nb);
        n_asrt++; if (rd !== 8'hA5 || h !== 1'b1) begin n_fail++; $display("FAIL midrst_wb_data: got %h/%b, expected a5/1", rd, h); end
    endtask

    task automatic test_write_miss();
        logic [7:0] rd;
        logic       h;
        int         lat, nb, base;
        base = log_q.size();
        access(1'b1, 16'h0200, 8'h3C, rd, h, lat, nb);
        n_asrt++; if (rd !== 8'h3C || h !== 1'b0) begin n_fail++; $display("FAIL wmiss_resp: got %h/%b, expected 3c/0", rd, h); end
        n_asrt++; if (nb !== 4) begin n_fail++; $display("FAIL wmiss_beats: got %0d, expected 4", nb); end
        for (int i = 0; i < nb && i < 4; i++) begin
            n_asrt++;
            if (log_q[base+i].we !== 1'b0 || log_q[base+i].addr !== 16'h0200 + 16'(i)) begin
                n_fail++;
                $display("FAIL wmiss_beat%0d: got we=%b addr=%h, expected we=0 addr=%h",
                         i, log_q[base+i].we, log_q[base+i].addr, 16'h0200 + 16'(i));
            end
        end
        access(1'b0, 16'h0200, 8'h00, rd, h, lat, nb);
        n_asrt++; if (rd !== 8'h3C || h !== 1'b1 || lat !== 2) begin n_fail++; $display("FAIL wmiss_readback: got %h/%b lat %0d, expected 3c/1 lat 2", rd, h, lat); end
    endtask

    initial begin
        rst_b         = 1'b0;
        cpu_req_valid = 1'b0;
        cpu_req_we    = 1'b0;
        cpu_req_addr  = 16'h0000;
        cpu_req_wdata = 8'h00;
        mem_req_ready = 1'b1;
        test_reset();
        test_read_miss_hit();
        test_write_hit();
        test_fill_evict();
        test_mem_stall();
        test_reset_midop();
        test_write_miss();
        repeat (2) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/cache_controller_nway.md
Name: cache_controller_nway

Overview:
- Parametrised N-way set-associative cache controller. It is the next generation of the fixed 4-way, age-based cache controller.
- Adds the following:
  - configurable ways, sets, line length and data width;
  - write-back with per-line dirty bits and write-allocate;
  - valid/ready handshakes toward both the CPU and the backing memory.
- Sits between the CPU-side request generator and the main-memory model. Replaces the opcode-driven control_unit/cache_memory pair.

Parameters:
- ADDR_W, 16: word address width.
- DATA_W, 8: data word width.
- WAYS, 4: associativity; power of two, minimum 2.
- SETS, 16: number of sets; power of two.
- BLOCK_WORDS, 4: words per line; power of two.

Ports:
- clk  in  1  system clock. Single clock domain, rising edge.
- rst_b  in  1  reset. Synchronous, active-low.
- cpu_req_valid  in  1  CPU request present.
- cpu_req_ready  out  1  controller can accept a request.
- cpu_req_we  in  1  1 = write, 0 = read.
- cpu_req_addr  in  ADDR_W  word address.
- cpu_req_wdata  in  DATA_W  write data.
- cpu_resp_valid  out  1  one-cycle response pulse.
- cpu_resp_rdata  out  DATA_W  read data. For a write, returns the written word.
- cpu_resp_hit  out  1  1 = request hit, valid with cpu_resp_valid.
- mem_req_valid  out  1  memory beat request.
- mem_req_ready  in  1  memory accepts the beat.
- mem_req_we  out  1  1 = writeback beat, 0 = refill read.
- mem_req_addr  out  ADDR_W  beat word address.
- mem_req_wdata  out  DATA_W  writeback data.
- mem_resp_valid  in  1  refill data returned.
- mem_resp_rdata  in  DATA_W  refill data.

Behaviour:
- Address split:
  - OFF = log2(BLOCK_WORDS), IDX = log2(SETS), TAG = ADDR_W - IDX - OFF.
  - addr = {tag, index, offset}.
- Reset (rst_b sampled 0 at a clk edge), effective from the next cycle, including mid-operation:
  - state returns to IDLE;
  - all valid and dirty bits cleared;
  - age[set][w] = w;
  - cpu_req_ready = 0 during reset and 1 in the first IDLE cycle after rst_b = 1;
  - cpu_resp_valid = 0, cpu_resp_hit = 0, cpu_resp_rdata = 0;
  - mem_req_valid = 0, mem_req_we = 0, mem_req_addr = 0, mem_req_wdata = 0.
  - Any in-flight mem_resp_valid is ignored.
- cpu_req_ready is 1 only in IDLE. A request is accepted on the edge where valid && ready; address, we and wdata are latched at that edge.
- FSM:
  - IDLE -> LOOKUP on accept.
  - LOOKUP (compare all ways in parallel):
    - hit -> RESP;
    - miss with a dirty victim -> WB;
    - miss with a clean or invalid victim -> REFILL.
  - WB: BLOCK_WORDS write beats to {victim_tag, index, i}, for i = 0 to BLOCK_WORDS-1. Each beat holds mem_req_valid, addr and wdata stable until mem_req_ready. Then go to REFILL.
  - REFILL: for i = 0 to BLOCK_WORDS-1:
    - issue a read beat to {req_tag, index, i};
    - after the handshake, drop mem_req_valid and wait for mem_resp_valid;
    - store the data in word i.
    - One beat outstanding at a time.
    - Then set valid = 1, dirty = 0, tag = req_tag, and go to RESP.
  - RESP:
    - perform the read or the write;
    - a write sets dirty = 1;
    - assert cpu_resp_valid for exactly one cycle, with cpu_resp_hit = the LOOKUP result;
    - return to IDLE.
- Hit latency: accept edge at cycle 0, LOOKUP at cycle 1, cpu_resp_valid high at cycle 2. The next request can be accepted at cycle 3.
- Victim selection: the lowest-index invalid way first; otherwise the way with age == WAYS-1.
- LRU update, in RESP on every access (hit or fill):
  - ways with age < the accessed way's age increment by 1;
  - the accessed way's age becomes 0;
  - ages remain a permutation of 0..WAYS-1;
  - no other set changes.
- Write miss: write-allocate. The refill happens first, then the word is merged, so the line ends dirty.
- mem_resp_valid outside the REFILL wait is ignored.
- cpu_req_valid while busy is simply not accepted.

Decomposition:
- Package cache_pkg holds:
  - the FSM state enum (IDLE, LOOKUP, WB, REFILL, RESP);
  - address-field width localparams derived via $clog2;
  - a function that extracts tag, index and offset.
- Sub-module cache_lru_ages(#WAYS, SETS):
  - holds the per-set age array;
  - provides the victim-by-age output and the update-on-access port;
  - applies the reset permutation.
- Tag, valid and dirty arrays plus data storage stay in the top level.

Test Plan (defaults; mem[a] = a[7:0] ^ 8'h5A):
- Reset, then read 0x0040 -> four reads at 0x0040..0x0043; resp rdata = 0x1A, hit = 0. Re-read 0x0042 -> hit = 1, rdata = 0x18, resp at cycle 2, no mem_req_valid.
- Write 0x0041 = 0xA5 (line resident) -> hit = 1, no memory traffic. Read 0x0041 -> 0xA5.
- Fill set 0 by reading 0x0000, 0x0040, 0x0080, 0x00C0, after writing 0xA5 to 0x0041. Read 0x0000, 0x0080, 0x00C0, then read 0x0100 -> writes 0x0040..0x0043 with 0x1A, 0xA5, 0x18, 0x19, then refill reads 0x0100..0x0103. Finally, 0x0000 is still a hit.
- Hold mem_req_ready = 0 for 5 cycles during a refill beat -> mem_req_valid, addr and we stay constant, with no duplicate beat.
- Assert rst_b = 0 for 1 cycle during the 2nd refill beat -> next cycle state IDLE and mem_req_valid = 0. Read 0x0040 -> miss.
- Write miss to 0x0200 = 0x3C -> four refill reads at 0x0200..0x0203, then hit = 0. Read 0x0200 -> hit, rdata = 0x3C.
